dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. The core drives MemWrite, DataAdr and WriteData in the M stage; this block answers with ReadData in the same cycle.
- Contains a word-addressed data RAM and a small MMIO register window:
  - TOHOST register for test termination.
  - Free-running cycle counter.
  - Store counter.
- Used as the data-side target in the top-level testbench.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, ≥4.
- MMIO_BASE, 32'hFFFF_FF00, base of the MMIO window; 256-byte aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; block is in reset while reset==0.
- MemWrite  input  1  store strobe from core (M stage).
- DataAdr  input  32  byte address from core (ALU result).
- WriteData  input  32  store data from core.
- ReadData  output  32  load data to core; combinational.
- tohost_valid  output  1  sticky; set by any store to TOHOST.
- tohost_data  output  32  last value stored to TOHOST.
- store_count  output  16  count of accepted RAM stores; saturating.
- misaligned_err  output  1  sticky; a store with DataAdr[1:0]!=0 was seen.

Behaviour:

Address decode:
- MMIO hit: DataAdr[31:8]==MMIO_BASE[31:8]. Everything else is RAM.
- RAM index = DataAdr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses alias/wrap modulo DEPTH_WORDS*4.
- MMIO offset = DataAdr[7:0]:
  - 0x00 TOHOST
  - 0x04 CYCLE
  - 0x08 STORECNT
  - all other offsets unmapped.

Reads:
- Purely combinational from DataAdr, zero-cycle latency.
- DataAdr[1:0] are ignored on reads; the aligned word is returned.
- RAM hit: returns the array word.
- TOHOST: returns tohost_data.
- CYCLE: returns the cycle counter.
- STORECNT: returns {16'b0, store_count}.
- Unmapped MMIO: returns 0.
- Read and write to the same RAM word in the same cycle: ReadData shows the old value; the new value is visible after the edge.

Writes (rising clk edge, only while reset==1 and MemWrite==1):
- DataAdr[1:0]!=0: no state change of any kind except misaligned_err<=1.
- Aligned RAM store: the word is written; store_count increments, saturating at 16'hFFFF.
- TOHOST store: tohost_data<=WriteData, tohost_valid<=1. A later TOHOST store overwrites the data; valid stays 1.
- CYCLE store: ignored.
- STORECNT store: store_count<=0. WriteData is ignored.
- Unmapped MMIO store: ignored. MMIO stores never increment store_count.

Cycle counter:
- 32-bit; increments on every rising edge while reset==1.
- Wraps from FFFF_FFFF to 0.
- Not writable.

Reset:
- Asynchronous assert. While reset==0: tohost_valid=0, tohost_data=0, cycle=0, store_count=0, misaligned_err=0.
- MemWrite is ignored while reset==0.
- RAM contents are not reset (undefined until written).
- Reset asserted mid-operation aborts any in-flight store; no RAM write occurs on an edge where reset==0.
- First count after release: cycle reads 1 after the first rising edge with reset==1.

Test Plan:
- Store 0xDEADBEEF to 0x10, then load 0x10 and 0x13 → both return 0xDEADBEEF; store_count==1; misaligned_err==0.
- With DEPTH_WORDS=64: store 0x11111111 to 0x04, then load 0x104 → 0x11111111 (alias). Same-cycle load of 0x04 during a store of 0x22222222 → old value 0x11111111; the next cycle returns 0x22222222.
- Store 0x55 to 0x06 (misaligned) → RAM word at 0x04 unchanged; store_count unchanged; misaligned_err==1 and stays 1 until reset.
- Store 0x1 then 0x7 to MMIO_BASE+0x00 → tohost_valid==1, tohost_data==0x7. Load MMIO_BASE+0x0C → 0. Store to MMIO_BASE+0x0C → no observable change.
- Release reset and run 10 edges; load MMIO_BASE+0x04 → 10. Perform 3 RAM stores, load MMIO_BASE+0x08 → 3. Store to MMIO_BASE+0x08 → reads 0 next cycle. Issue 70000 RAM stores → store_count saturates at 0xFFFF.
- Pull reset low between clock edges after activity → all outputs go to 0 immediately, without waiting for a clk edge. A MemWrite asserted during reset leaves RAM unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus TOHOST/CYCLE/STORECNT MMIO window
//
// Purpose: answers the core's M-stage data port. Loads are combinational
// (zero latency); stores commit on the rising clk edge.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   MemWrite       store strobe
//   DataAdr        byte address
//   WriteData      store data
//   ReadData       combinational load data
//   tohost_valid   sticky, set by any TOHOST store
//   tohost_data    last value stored to TOHOST
//   store_count    saturating count of accepted RAM stores
//   misaligned_err sticky, set by any store with DataAdr[1:0] != 0
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic [15:0] store_count,
  output logic        misaligned_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  // MMIO registers addressed by word offset within the 256-byte window.
  localparam logic [5:0] OffTohost   = 6'h00;
  localparam logic [5:0] OffCycle    = 6'h01;
  localparam logic [5:0] OffStoreCnt = 6'h02;

  logic [31:0]     ram [DEPTH_WORDS];
  logic [31:0]     cycleCount;
  logic            mmioHit;
  logic            aligned;
  logic [IdxW-1:0] ramIdx;
  logic [5:0]      mmioWord;

  assign mmioHit  = (DataAdr[31:8] == MMIO_BASE[31:8]);
  assign aligned  = (DataAdr[1:0] == 2'b00);
  // Upper address bits are dropped, so RAM aliases modulo DEPTH_WORDS*4.
  assign ramIdx   = DataAdr[IdxW+1:2];
  assign mmioWord = DataAdr[7:2];

  always_comb begin
    ReadData = '0;
    if (mmioHit) begin
      case (mmioWord)
        OffTohost:   ReadData = tohost_data;
        OffCycle:    ReadData = cycleCount;
        OffStoreCnt: ReadData = {16'b0, store_count};
        default:     ReadData = '0;
      endcase
    end else begin
      ReadData = ram[ramIdx];
    end
  end

  // RAM has no reset; gating on reset blocks writes on any edge seen while
  // the block is held in reset.
  always_ff @(posedge clk) begin
    if (reset && MemWrite && aligned && !mmioHit) begin
      ram[ramIdx] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCount     <= '0;
      tohost_valid   <= 1'b0;
      tohost_data    <= '0;
      store_count    <= '0;
      misaligned_err <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (MemWrite) begin
        if (!aligned) begin
          // A misaligned store changes nothing but the error flag.
          misaligned_err <= 1'b1;
        end else if (!mmioHit) begin
          if (store_count != 16'hFFFF) begin
            store_count <= store_count + 16'd1;
          end
        end else begin
          case (mmioWord)
            OffTohost: begin
              tohost_data  <= WriteData;
              tohost_valid <= 1'b1;
            end
            OffStoreCnt: store_count <= '0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a load scoreboard
module tb_dmem_responder;

  localparam logic [31:0] Base = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic [15:0] store_count;
  logic        misaligned_err;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];

  dmem_responder #(.DEPTH_WORDS(64), .MMIO_BASE(Base)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .tohost_valid(tohost_valid),
    .tohost_data(tohost_data),
    .store_count(store_count),
    .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pops the oldest expected load value and compares it with ReadData.
  task automatic checkRead(input string tag);
    checkVal(tag, ReadData, expQ.pop_front());
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr  = a;
    expQ.push_back(exp);
    #1;
    checkRead(tag);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_valid"}, 32'(tohost_valid), 32'd0);
    checkVal({tag, "_data"}, tohost_data, 32'd0);
    checkVal({tag, "_scnt"}, 32'(store_count), 32'd0);
    checkVal({tag, "_mis"}, 32'(misaligned_err), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    checkAllZero("rst");
    load(Base + 32'h4, 32'd0, "rst_cycle");

    // Cycle counter after release: 10 edges -> 10.
    @(negedge clk);
    reset   = 1'b1;
    DataAdr = Base + 32'h4;
    repeat (10) @(posedge clk);
    #1;
    expQ.push_back(32'd10);
    checkRead("cycle_10");

    // Basic store/load, sub-word address bits ignored on reads.
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10, 32'hDEAD_BEEF, "ld_10");
    load(32'h13, 32'hDEAD_BEEF, "ld_13");
    checkVal("scnt_1", 32'(store_count), 32'd1);
    checkVal("mis_0", 32'(misaligned_err), 32'd0);

    // Aliasing and same-cycle read-before-write.
    store(32'h04, 32'h1111_1111);
    load(32'h104, 32'h1111_1111, "alias_104");
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = 32'h04;
    WriteData = 32'h2222_2222;
    expQ.push_back(32'h1111_1111);
    #1;
    checkRead("rw_old");
    @(negedge clk);
    MemWrite = 1'b0;
    expQ.push_back(32'h2222_2222);
    #1;
    checkRead("rw_new");

    // Misaligned store changes nothing but the error flag.
    store(32'h06, 32'h55);
    load(32'h04, 32'h2222_2222, "mis_ram");
    checkVal("mis_scnt", 32'(store_count), 32'd3);
    checkVal("mis_set", 32'(misaligned_err), 32'd1);

    // TOHOST and unmapped MMIO.
    store(Base, 32'h1);
    store(Base, 32'h7);
    checkVal("th_valid", 32'(tohost_valid), 32'd1);
    checkVal("th_data", tohost_data, 32'h7);
    load(Base + 32'hC, 32'd0, "unmap_rd");
    store(Base + 32'hC, 32'hABCD_1234);
    checkVal("unmap_th", tohost_data, 32'h7);
    checkVal("unmap_scnt", 32'(store_count), 32'd3);
    load(Base, 32'h7, "th_rd");
    load(Base + 32'h8, 32'd3, "scnt_rd3");
    checkVal("mis_sticky", 32'(misaligned_err), 32'd1);

    // STORECNT clear, then count 3 stores.
    store(Base + 32'h8, 32'hFFFF_FFFF);
    load(Base + 32'h8, 32'd0, "scnt_clr");
    store(32'h30, 32'hA);
    store(32'h34, 32'hB);
    store(32'h38, 32'hC);
    load(Base + 32'h8, 32'd3, "scnt_3");
    load(32'h34, 32'hB, "ld_34");

    // Saturation: 65535 stores reach FFFF, further stores hold it.
    store(Base + 32'h8, 32'h0);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = 32'h20;
    WriteData = 32'h5A5A_5A5A;
    repeat (65534) @(posedge clk);
    #1;
    checkVal("scnt_fffe", 32'(store_count), 32'h0000_FFFE);
    repeat (1) @(posedge clk);
    #1;
    checkVal("scnt_ffff", 32'(store_count), 32'h0000_FFFF);
    repeat (70000 - 65535) @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    checkVal("scnt_sat", 32'(store_count), 32'h0000_FFFF);

    // Asynchronous reset between edges, and stores ignored during reset.
    @(posedge clk);
    #2;
    reset   = 1'b0;
    DataAdr = Base + 32'h4;
    #1;
    checkAllZero("arst");
    expQ.push_back(32'd0);
    checkRead("arst_cycle");
    MemWrite  = 1'b1;
    DataAdr   = 32'h10;
    WriteData = 32'h0000_0BAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b1;
    load(32'h10, 32'hDEAD_BEEF, "rst_nowr");
    checkVal("rst_nowr_scnt", 32'(store_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
